// File: rtl/spram_bank_sched.sv
// Push/pop scheduler for a FIFO split across two single-port RAM banks.
// Even slots live in bank 0, odd slots in bank 1; same-bank clashes go round-robin.
module spram_bank_sched #(
    parameter int DW = 32,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_valid,
    output logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_dvalid,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          en0,
    output logic          we0,
    output logic [AW-2:0] addr0,
    output logic [DW-1:0] din0,
    input  logic [DW-1:0] dout0,
    output logic          en1,
    output logic          we1,
    output logic [AW-2:0] addr1,
    output logic [DW-1:0] din1,
    input  logic [DW-1:0] dout1
);

    logic [AW:0] wp;
    logic [AW:0] rp;
    logic        prio;
    logic        rsel;

    logic push_el;
    logic pop_el;
    logic conflict;
    logic wr_gnt;
    logic rd_gnt;

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) &&
                   (wp[AW-1:0] == rp[AW-1:0]);
    assign count = wp - rp;

    // rst gates the grants so nothing leaks out while reset is held
    assign push_el  = rst && wr_valid && !full && !flush;
    assign pop_el   = rst && rd_valid && !empty && !flush;
    assign conflict = push_el && pop_el && (wp[0] == rp[0]);

    assign wr_gnt = push_el && (!conflict || prio);
    assign rd_gnt = pop_el && (!conflict || !prio);

    assign wr_ready = wr_gnt;
    assign rd_ready = rd_gnt;

    assign rd_data = rsel ? dout1 : dout0;

    always_comb begin
        en0   = 1'b0;
        we0   = 1'b0;
        addr0 = '0;
        din0  = '0;
        en1   = 1'b0;
        we1   = 1'b0;
        addr1 = '0;
        din1  = '0;
        if (wr_gnt) begin
            if (wp[0]) begin
                en1   = 1'b1;
                we1   = 1'b1;
                addr1 = wp[AW-1:1];
                din1  = wr_data;
            end else begin
                en0   = 1'b1;
                we0   = 1'b1;
                addr0 = wp[AW-1:1];
                din0  = wr_data;
            end
        end
        // a granted pop never shares a bank with a granted push
        if (rd_gnt) begin
            if (rp[0]) begin
                en1   = 1'b1;
                addr1 = rp[AW-1:1];
            end else begin
                en0   = 1'b1;
                addr0 = rp[AW-1:1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp        <= '0;
            rp        <= '0;
            prio      <= 1'b0;
            rsel      <= 1'b0;
            rd_dvalid <= 1'b0;
        end else if (flush) begin
            wp        <= '0;
            rp        <= '0;
            prio      <= 1'b0;
            rd_dvalid <= 1'b0;
        end else begin
            wp        <= wp + {{AW{1'b0}}, wr_gnt};
            rp        <= rp + {{AW{1'b0}}, rd_gnt};
            rd_dvalid <= rd_gnt;
            if (rd_gnt) begin
                rsel <= rp[0];
            end
            if (conflict) begin
                prio <= ~prio;
            end
        end
    end

endmodule

// File: doc/spram_bank_sched.md
# spram_bank_sched

Access scheduler for a FIFO built from two single-port RAM banks, each with 1-cycle read latency. Even FIFO slots live in bank 0 and odd slots in bank 1. The block accepts push and pop requests over valid/ready handshakes, keeps the FIFO pointers and occupancy, and drives both banks' enable, write-enable, address and data. When a push and a pop target the same bank in the same cycle, it grants one of them using round-robin priority. It sits between the FIFO top level and the two RAM instances.

## Interface
- DW, 32, data width
- AW, 3, log2 of total FIFO depth (2^AW entries; each bank holds 2^(AW-1) words); AW >= 2
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of pointers, count and priority
- wr_valid  in  1  push request
- wr_ready  out  1  push accepted this cycle when wr_valid=1
- wr_data  in  DW  push data
- rd_valid  in  1  pop request
- rd_ready  out  1  pop accepted this cycle when rd_valid=1
- rd_data  out  DW  popped word; meaningful only while rd_dvalid=1
- rd_dvalid  out  1  rd_data valid, 1 cycle after pop acceptance
- full, empty  out  1  occupancy flags
- count  out  AW+1  current occupancy, 0..2^AW
- en0, we0  out  1  bank 0 enable and write-enable
- addr0  out  AW-1  bank 0 word address
- din0  out  DW  bank 0 write data
- dout0  in  DW  bank 0 read data
- en1, we1, addr1, din1, dout1  bank 1 signals, same widths and meanings as bank 0

## Operation
- Pointers:
  - wp and rp are each AW+1 bits and reset to 0.
  - The slot bank is ptr[0]; the bank word address is ptr[AW-1:1].
  - full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]); empty = (wp == rp).
  - count = wp - rp, computed modulo 2^(AW+1).
- Eligibility:
  - A push is eligible when wr_valid && !full && !flush.
  - A pop is eligible when rd_valid && !empty && !flush.
  - Same-cycle bypass is not supported: a push into an empty FIFO does not make a same-cycle pop eligible.
- Conflict: both requests are eligible and wp[0] == rp[0]. This can only happen when count is even and nonzero, and never when full.
- Grant:
  - No conflict: every eligible request is granted.
  - Conflict: grant goes to the side named by the 1-bit register `prio` (0 = read, 1 = write). `prio` then flips to the loser.
  - `prio` changes only on a conflict.
- wr_ready and rd_ready are the combinational grants for the current cycle. Both are forced to 0 while rst is low or flush is high.
- Granted push:
  - Drive en=1 and we=1 on bank wp[0], with addr = wp[AW-1:1] and din = wr_data.
  - wp increments (wraps naturally).
- Granted pop:
  - Drive en=1 and we=0 on bank rp[0], with addr = rp[AW-1:1].
  - Register the selected bank into rsel and set rd_dvalid=1 on the next cycle.
  - rp increments.
- Bank outputs:
  - An idle bank has en=0 and we=0.
  - addr and din are don't-care while en=0, but must be driven to 0 to avoid X on the bus.
- rd_data is combinational: rsel ? dout1 : dout0.
- Simultaneous push and pop on different banks: count is unchanged.
- Pop while full: allowed. wr_ready stays 0 in that cycle; a push may be granted on the following cycle.
- flush:
  - Clears wp, rp and prio to 0.
  - rd_dvalid for a pop granted in the previous cycle still asserts.
  - No bank access occurs in the flush cycle.

## Timing
- Reset (asynchronous, rst=0): wp=rp=0, prio=0, rsel=0, rd_dvalid=0, empty=1, full=0, count=0, wr_ready=rd_ready=0, en*=we*=0.
  - Reset deasserted mid-transfer: any in-flight pop data is discarded (rd_dvalid=0).
- Push latency: the bank write happens on the grant cycle's clock edge. The word can be popped from the next cycle onward.
- Pop latency: rd_dvalid and rd_data are valid exactly 1 cycle after rd_ready=1. Back-to-back pops give rd_dvalid=1 on consecutive cycles.
- Throughput: 1 push plus 1 pop per cycle whenever their banks differ. On a conflict, only one is granted.
- full, empty and count are registered and reflect every grant from the previous edge.

## Test plan
- Fill and drain, AW=3:
  - Push 0x10..0x17 on 8 consecutive cycles -> wr_ready=1 on each; then full=1, count=8, wr_ready=0.
  - Bank 0 addr0..3 holds 0x10,0x12,0x14,0x16.
  - Then pop 8 times -> rd_dvalid on cycles 2..9 returning 0x10..0x17 in order; empty=1 after.
- Conflict round-robin:
  - With count=2, assert wr_valid and rd_valid -> rd_ready=1, wr_ready=0, count=1, prio=1.
  - Push alone to reach count=2, then assert both again -> wr_ready=1, rd_ready=0, count=3.
- Streaming: with count=1, hold both requests for 20 cycles -> both granted every cycle, count stays 1, data order preserved.
- Boundaries:
  - Empty plus pop-and-push in the same cycle -> rd_ready=0, wr_ready=1.
  - Full plus pop-and-push in the same cycle -> rd_ready=1, wr_ready=0; the next cycle's push is granted.
- Pointer wrap: push and pop 20 words through depth 8 -> all returned in order, no spurious full/empty.
- Flush and async reset:
  - Flush at count=5 -> next cycle count=0, empty=1, prio=0; a pop granted the cycle before still yields rd_dvalid.
  - rst pulsed low mid-stream -> all outputs take reset values immediately, without waiting for a clock edge.
